// File: rtl/prog_sequencer_pkg.sv
// prog_sequencer_pkg: sequencer state encoding and cpu_top instruction-format helpers
// (opcode[10:8], op1[7:4], op2[3:0]).
package prog_sequencer_pkg;
    localparam int CPU_INSTR_W = 11;
    localparam logic [2:0] OPC_NOP = 3'd0;
    localparam logic [2:0] OPC_STO = 3'd1;
    localparam logic [2:0] OPC_ADD = 3'd2;
    localparam logic [2:0] OPC_SUB = 3'd3;
    localparam logic [2:0] OPC_AND = 3'd4;
    localparam logic [2:0] OPC_OR  = 3'd5;
    typedef enum logic [2:0] {
        SEQ_IDLE, SEQ_FETCH, SEQ_EXEC, SEQ_STORE, SEQ_DONE
    } seq_state_t;
    function automatic logic [2:0] get_opcode(input logic [CPU_INSTR_W-1:0] i);
        return i[10:8];
    endfunction
    function automatic logic [3:0] get_op1(input logic [CPU_INSTR_W-1:0] i);
        return i[7:4];
    endfunction
    function automatic logic [3:0] get_op2(input logic [CPU_INSTR_W-1:0] i);
        return i[3:0];
    endfunction
    function automatic logic [CPU_INSTR_W-1:0] make_instr(input logic [2:0] opc, input logic [3:0] a,
                                                          input logic [3:0] b);
        return {opc, a, b};
    endfunction
endpackage

// File: rtl/prog_sequencer_mem.sv
// prog_sequencer_mem: 1W/1R program RAM with registered read; a same-cycle write to the
// read address is forwarded so a program word loaded just before start is seen.
module prog_sequencer_mem #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 11
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);
    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_wr_addr] <= i_wr_data;
        o_rd_data <= (i_we && i_wr_addr == i_rd_addr) ? i_wr_data : r_mem[i_rd_addr];
    end
endmodule

// File: rtl/prog_sequencer.sv
// prog_sequencer: loads a program from the host and issues it to cpu_top, one instruction per
// FETCH/EXEC/STORE slot, with one trace record per retired instruction. SEQ_LOOP_EN adds loop_mode.
module prog_sequencer
    import prog_sequencer_pkg::*;
#(
    parameter int                 ADDR_W     = 8,
    parameter int                 INSTR_W    = CPU_INSTR_W,
    parameter logic [INSTR_W-1:0] FILL_INSTR = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load_we,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic [ADDR_W:0]    prog_len,
    input  logic               start,
    input  logic               abort,
`ifdef SEQ_LOOP_EN
    input  logic               loop_mode,
`endif
    output logic               cpu_rst_n,
    output logic [INSTR_W-1:0] instruction,
    input  logic [3:0]         cpu_res,
    input  logic               cpu_cout,
    output logic               busy,
    output logic               done,
    output logic               trace_valid,
    output logic [ADDR_W-1:0]  trace_pc,
    output logic [INSTR_W-1:0] trace_instr,
    output logic [3:0]         trace_res,
    output logic               trace_cout
);
    seq_state_t         r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W:0]    r_len;
    logic               r_abort;
    logic               r_pend;
    logic [INSTR_W-1:0] w_rd_data;
    logic [ADDR_W-1:0]  w_rd_addr;
    logic               w_run;
    logic               w_last;
    logic               w_loop;
    logic               w_stop;
    logic               w_we;

`ifdef SEQ_LOOP_EN
    assign w_loop = loop_mode;
`else
    assign w_loop = 1'b0;
`endif
    assign w_run     = r_state inside {SEQ_FETCH, SEQ_EXEC, SEQ_STORE};
    assign w_last    = {1'b0, r_pc} == r_len - 1'b1;
    // Prefetch the next slot's word during the current slot; idle states keep word 0 ready.
    assign w_rd_addr = (w_run && !w_last) ? r_pc + 1'b1 : '0;
    assign w_we      = load_we && !w_run;
    assign w_stop    = abort || r_abort || (w_last && !w_loop);

    prog_sequencer_mem #(.ADDR_W(ADDR_W), .DATA_W(INSTR_W)) u_mem (
        .clk      (clk),
        .i_we     (w_we),
        .i_wr_addr(load_addr),
        .i_wr_data(load_data),
        .i_rd_addr(w_rd_addr),
        .o_rd_data(w_rd_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= SEQ_IDLE;
            r_pc        <= '0;
            r_len       <= '0;
            r_abort     <= 1'b0;
            r_pend      <= 1'b0;
            cpu_rst_n   <= 1'b0;
            instruction <= FILL_INSTR;
            busy        <= 1'b0;
            done        <= 1'b0;
            trace_valid <= 1'b0;
            trace_pc    <= '0;
            trace_instr <= '0;
            trace_res   <= '0;
            trace_cout  <= 1'b0;
        end else begin
            trace_valid <= 1'b0;
            r_abort     <= (r_state == SEQ_FETCH || r_state == SEQ_EXEC) && (r_abort || abort);
            case (r_state)
                SEQ_IDLE: begin
                    if (r_pend || (start && prog_len != '0)) begin
                        if (!r_pend) r_len <= prog_len;
                        r_pend      <= 1'b0;
                        r_pc        <= '0;
                        cpu_rst_n   <= 1'b1;
                        instruction <= w_rd_data;
                        busy        <= 1'b1;
                        r_state     <= SEQ_FETCH;
                    end else if (start) begin
                        done    <= 1'b1;
                        r_state <= SEQ_DONE;
                    end
                end
                SEQ_FETCH: r_state <= SEQ_EXEC;
                SEQ_EXEC:  r_state <= SEQ_STORE;
                SEQ_STORE: begin
                    trace_valid <= 1'b1;
                    trace_pc    <= r_pc;
                    trace_instr <= instruction;
                    trace_res   <= cpu_res;
                    trace_cout  <= cpu_cout;
                    if (w_stop) begin
                        instruction <= FILL_INSTR;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        r_state     <= SEQ_DONE;
                    end else begin
                        r_pc        <= w_last ? '0 : r_pc + 1'b1;
                        instruction <= w_rd_data;
                        r_state     <= SEQ_FETCH;
                    end
                end
                SEQ_DONE: begin
                    // Restart pulses cpu reset for one cycle in IDLE, then resumes via r_pend.
                    if (start && prog_len != '0) begin
                        r_len     <= prog_len;
                        r_pend    <= 1'b1;
                        cpu_rst_n <= 1'b0;
                        done      <= 1'b0;
                        r_state   <= SEQ_IDLE;
                    end
                end
                default: r_state <= SEQ_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: directed table, corner sequences and random runs against a slot-level model
// (retired pcs, 3-cycle cadence, memory image); SEQ_LOOP_EN enables the loop-mode sequence.
module tb_prog_sequencer;
    import prog_sequencer_pkg::*;
    localparam logic [10:0] FILL = 11'h000;

    logic        clk, reset_n, load_we, start, abort, cpu_rst_n, busy, done;
    logic        trace_valid, trace_cout, cpu_cout;
    logic [7:0]  load_addr, trace_pc;
    logic [10:0] load_data, instruction, trace_instr;
    logic [8:0]  prog_len;
    logic [3:0]  cpu_res, trace_res;
`ifdef SEQ_LOOP_EN
    logic        loop_mode;
`endif

    logic [10:0] mem [256];
    bit          st_done;
    int          checks, errors;

    prog_sequencer dut (
        .clk(clk), .reset_n(reset_n), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .prog_len(prog_len), .start(start), .abort(abort),
`ifdef SEQ_LOOP_EN
        .loop_mode(loop_mode),
`endif
        .cpu_rst_n(cpu_rst_n), .instruction(instruction), .cpu_res(cpu_res), .cpu_cout(cpu_cout),
        .busy(busy), .done(done), .trace_valid(trace_valid), .trace_pc(trace_pc),
        .trace_instr(trace_instr), .trace_res(trace_res), .trace_cout(trace_cout)
    );

    // Stand-in for cpu_top: result and carry are fixed functions of the issued instruction.
    function automatic logic [3:0] f_res(input logic [10:0] i);
        return i[3:0] ^ i[7:4];
    endfunction
    function automatic logic f_cout(input logic [10:0] i);
        return ^i;
    endfunction
    assign cpu_res  = f_res(instruction);
    assign cpu_cout = f_cout(instruction);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        st_done = 1'b0;
    endtask

    task automatic load(input logic [7:0] a, input logic [10:0] d);
        load_we = 1'b1; load_addr = a; load_data = d; mem[a] = d;
        @(posedge clk);
        #1 load_we = 1'b0;
    endtask

    // One program run; model: slots 0..n-1 retire, trace k = 3*(slot+1)+lag edges after start.
    task automatic run(input int len, input int abort_slot, input bit noise, output int ntr, output int kdone);
        int lag, n, j, jn, last;
        bit act;
        lag  = st_done ? 1 : 0;
        n    = (abort_slot >= 0 && abort_slot < len) ? abort_slot + 1 : len;
        last = 3 * n + lag + 2;
        prog_len = 9'(len); start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        ntr = 0; kdone = -1;
        for (int k = 0; k <= last; k++) begin
            j   = k - lag;
            act = j >= 0 && j < 3 * n;
            @(negedge clk);
            chk("trace_valid", trace_valid, 32'(j >= 3 && j % 3 == 0 && j / 3 <= n));
            if (j >= 3 && j % 3 == 0 && j / 3 <= n) begin
                chk("trace_pc", trace_pc, j / 3 - 1);
                chk("trace_instr", trace_instr, mem[j / 3 - 1]);
                chk("trace_res", trace_res, f_res(mem[j / 3 - 1]));
                chk("trace_cout", trace_cout, f_cout(mem[j / 3 - 1]));
            end
            chk("busy", busy, 32'(act));
            chk("done", done, 32'(j >= 3 * n));
            chk("cpu_rst_n", cpu_rst_n, 32'(k >= lag));
            chk("instruction", instruction, act ? mem[j / 3] : FILL);
            ntr += int'(trace_valid);
            if (done && kdone < 0) kdone = k;
            @(posedge clk);
            #1 load_we = 1'b0; abort = 1'b0; start = 1'b0;
            jn = j + 1;
            if (abort_slot >= 0 && jn == 3 * abort_slot + 1) abort = 1'b1;
            if (noise && jn >= 0 && jn < 3 * n && $urandom_range(0, 2) == 0) begin
                load_we = 1'b1; load_addr = 8'($urandom); load_data = 11'($urandom);
            end
            if (noise && jn >= 0 && jn < 3 * n && $urandom_range(0, 4) == 0) start = 1'b1;
            if (noise && k + 1 <= last && jn >= 3 * n && $urandom_range(0, 1) == 0) abort = 1'b1;
        end
        st_done = 1'b1;
    endtask

    typedef struct {
        bit rst_first;
        int len;
        int abort_slot;
        int exp_tr;
        int exp_done;
    } vec_t;
    vec_t tbl [7];

    initial begin
        int ntr, kd, len, a, n;
        tbl[0] = '{1, 3, -1, 3, 9};
        tbl[1] = '{0, 5, 1, 2, 7};
        tbl[2] = '{1, 1, -1, 1, 3};
        tbl[3] = '{0, 1, 0, 1, 4};
        tbl[4] = '{0, 4, 3, 4, 13};
        tbl[5] = '{0, 256, -1, 256, 769};
        tbl[6] = '{1, 2, 0, 1, 3};
        checks = 0; errors = 0;
        reset_n = 1'b0; load_we = 1'b0; start = 1'b0; abort = 1'b0;
        load_addr = '0; load_data = '0; prog_len = '0;
`ifdef SEQ_LOOP_EN
        loop_mode = 1'b0;
`endif
        @(negedge clk);
        chk("rst_cpu_rst_n", cpu_rst_n, 0);
        chk("rst_instruction", instruction, FILL);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_trace_valid", trace_valid, 0);
        chk("rst_trace_pc", trace_pc, 0);
        chk("rst_trace_instr", trace_instr, 0);
        chk("rst_trace_res", trace_res, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        st_done = 1'b0;

        for (int i = 0; i < 256; i++) load(8'(i), 11'($urandom));
        load(8'd0, make_instr(OPC_STO, 4'd3, 4'd0));
        load(8'd1, make_instr(OPC_ADD, 4'd5, 4'd6));
        load(8'd2, make_instr(OPC_SUB, 4'd9, 4'd2));

        foreach (tbl[i]) begin
            if (tbl[i].rst_first) do_reset();
            run(tbl[i].len, tbl[i].abort_slot, 1'b0, ntr, kd);
            chk("tbl_traces", ntr, tbl[i].exp_tr);
            chk("tbl_done_cycle", kd, tbl[i].exp_done);
        end

        // Zero-length program: straight to DONE, cpu stays in reset, no trace.
        do_reset();
        prog_len = 9'd0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("len0_done", done, 1);
            chk("len0_busy", busy, 0);
            chk("len0_cpu_rst_n", cpu_rst_n, 0);
            chk("len0_trace_valid", trace_valid, 0);
        end
        st_done = 1'b1;

        // Asynchronous reset in STORE of pc=2: outputs drop at once, pc=2 never retires.
        do_reset();
        prog_len = 9'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #2 chk("pre_rst_busy", busy, 1);
        chk("pre_rst_instr", instruction, mem[2]);
        reset_n = 1'b0;
        #1 chk("arst_cpu_rst_n", cpu_rst_n, 0);
        chk("arst_busy", busy, 0);
        chk("arst_instruction", instruction, FILL);
        chk("arst_trace_pc", trace_pc, 0);
        chk("arst_trace_instr", trace_instr, 0);
        repeat (4) begin
            @(negedge clk);
            chk("arst_no_trace", trace_valid, 0);
            chk("arst_done", done, 0);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        st_done = 1'b0;

`ifdef SEQ_LOOP_EN
        // Loop mode, len=2, restarted from DONE: pcs alternate until abort in EXEC of slot 10.
        run(1, -1, 1'b0, ntr, kd);
        loop_mode = 1'b1; prog_len = 9'd2; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < 38; k++) begin
            @(negedge clk);
            chk("loop_tv", trace_valid, 32'(k - 1 >= 3 && (k - 1) % 3 == 0 && k - 1 <= 33));
            if (k - 1 >= 3 && (k - 1) % 3 == 0 && k - 1 <= 33) chk("loop_pc", trace_pc, ((k - 1) / 3 - 1) % 2);
            chk("loop_busy", busy, 32'(k >= 1 && k - 1 < 33));
            chk("loop_done", done, 32'(k - 1 >= 33));
            @(posedge clk);
            #1 abort = (k == 31);
        end
        abort = 1'b0; loop_mode = 1'b0;
`endif

        for (int r = 0; r < 30; r++) begin
            if ($urandom_range(0, 4) == 0) do_reset();
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) load(8'(i), 11'($urandom));
            a = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : -1;
            n = (a >= 0) ? a + 1 : len;
            kd = st_done ? 1 : 0;
            run(len, a, 1'b1, ntr, kd);
            chk("rnd_traces", ntr, n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
